// File: rtl/rr_priority_arbiter.sv
// Registered N-way request arbiter with run-time fixed-priority / round-robin mode.
// A grant is held until the owner pulses done or drops its request. At least one
// idle cycle always separates two consecutive grants.
module rr_priority_arbiter #(
  parameter int unsigned N = 16,
  parameter int unsigned W = $clog2(N)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         mode,
  input  logic         done,
  output logic [N-1:0] grant,
  output logic [W-1:0] grant_code,
  output logic         grant_valid,
  output logic         busy
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e         state_q, state_d;
  logic [N-1:0]   grant_q, grant_d;
  logic [W-1:0]   code_q, code_d;
  logic [W-1:0]   ptr_q, ptr_d;
  logic [W-1:0]   win;
  int             base;
  int             idx;

  // Winner search. Later loop iterations override earlier ones, so the highest
  // priority is the last index visited: base-1, then base-2, ... down to base.
  // In fixed mode base is 0, which reduces to "highest set index wins".
  always_comb begin
    win  = '0;
    idx  = 0;
    base = mode ? int'(ptr_q) : 0;
    for (int j = 0; j < int'(N); j++) begin
      idx = (base + j) % int'(N);
      if (req[idx]) begin
        win = W'(idx);
      end
    end
  end

  // Next-state logic: arbitrate in idle, hold the grant until release.
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    code_d  = code_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      StIdle: begin
        if (|req) begin
          grant_d      = '0;
          grant_d[win] = 1'b1;
          code_d       = win;
          ptr_d        = win;
          state_d      = StGrant;
        end
      end
      StGrant: begin
        // Other requesters and mode are ignored while a grant is held.
        if (done || !req[code_q]) begin
          grant_d = '0;
          code_d  = '0;
          state_d = StIdle;
        end
      end
      default: begin
        grant_d = '0;
        code_d  = '0;
        state_d = StIdle;
      end
    endcase
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      grant_q <= '0;
      code_q  <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      code_q  <= code_d;
      ptr_q   <= ptr_d;
    end
  end

  assign grant       = grant_q;
  assign grant_code  = code_q;
  assign grant_valid = |grant_q;
  assign busy        = (state_q == StGrant);

endmodule

// File: tb/tb_rr_priority_arbiter.sv
// Directed self-checking bench for rr_priority_arbiter with N=16.
module tb_rr_priority_arbiter;

  localparam int unsigned N = 16;
  localparam int unsigned W = 4;

  logic         clk;
  logic         reset;
  logic [N-1:0] req;
  logic         mode;
  logic         done;
  logic [N-1:0] grant;
  logic [W-1:0] grant_code;
  logic         grant_valid;
  logic         busy;

  int errors = 0;
  int checks = 0;

  rr_priority_arbiter #(.N(N)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .mode       (mode),
    .done       (done),
    .grant      (grant),
    .grant_code (grant_code),
    .grant_valid(grant_valid),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Compare all outputs against an expected grant state.
  task automatic check_out(input string tag, input logic [N-1:0] exp_grant,
                           input logic [W-1:0] exp_code, input logic exp_held);
    check({tag, ".grant"}, 32'(grant), 32'(exp_grant));
    check({tag, ".code"},  32'(grant_code), 32'(exp_code));
    check({tag, ".valid"}, 32'(grant_valid), 32'(exp_held));
    check({tag, ".busy"},  32'(busy), 32'(exp_held));
  endtask

  // Advance one clock; inputs are changed and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [W-1:0] exp_code;

  initial begin
    reset = 1'b1;
    req   = 16'hFFFF;
    mode  = 1'b0;
    done  = 1'b0;

    // 1: outputs stay zero throughout reset, then highest requester wins.
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out("t1_reset", 16'h0000, 4'd0, 1'b0);
    end
    reset = 1'b0;
    tick();
    check_out("t1_first", 16'h8000, 4'd15, 1'b1);
    req = 16'h0000;
    tick();
    check_out("t1_drop", 16'h0000, 4'd0, 1'b0);

    // 2: fixed priority, done release, regrant after one idle cycle.
    mode = 1'b0;
    req  = 16'h0012;
    tick();
    check_out("t2_grant", 16'h0010, 4'd4, 1'b1);
    done = 1'b1;
    tick();
    check_out("t2_release", 16'h0000, 4'd0, 1'b0);
    done = 1'b0;
    tick();
    check_out("t2_regrant", 16'h0010, 4'd4, 1'b1);
    req = 16'h0000;
    tick();
    check_out("t2_idle", 16'h0000, 4'd0, 1'b0);

    // 3: round-robin alternation between requesters 15 and 0 (pointer cleared).
    reset = 1'b1;
    tick();
    reset = 1'b0;
    mode  = 1'b1;
    req   = 16'h8001;
    for (int i = 0; i < 4; i++) begin
      exp_code = (i % 2 == 0) ? 4'd15 : 4'd0;
      tick();
      check("t3_code", 32'(grant_code), 32'(exp_code));
      check("t3_grant", 32'(grant), 32'(16'h0001 << exp_code));
      done = 1'b1;
      tick();
      check("t3_gap", 32'(grant), 32'h0);
      done = 1'b0;
    end
    req = 16'h0000;
    tick();

    // 4: all requesting in round-robin gives a full descending rotation.
    req = 16'hFFFF;
    for (int i = 0; i < 17; i++) begin
      exp_code = 4'(15 - (i % 16));
      tick();
      check("t4_code", 32'(grant_code), 32'(exp_code));
      done = 1'b1;
      tick();
      done = 1'b0;
    end
    req = 16'h0000;
    tick();

    // 5: owner dropping its request releases without done; done in idle is ignored.
    mode = 1'b0;
    req  = 16'h0010;
    tick();
    check_out("t5_grant", 16'h0010, 4'd4, 1'b1);
    req = 16'h0000;
    tick();
    check_out("t5_drop", 16'h0000, 4'd0, 1'b0);
    done = 1'b1;
    tick();
    check_out("t5_idle_done", 16'h0000, 4'd0, 1'b0);
    done = 1'b0;

    // 6: reset mid-grant clears grant and pointer.
    mode = 1'b1;
    req  = 16'h0200;
    tick();
    check_out("t6_grant", 16'h0200, 4'd9, 1'b1);
    reset = 1'b1;
    tick();
    check_out("t6_reset", 16'h0000, 4'd0, 1'b0);
    reset = 1'b0;
    req   = 16'h0201;
    tick();
    check_out("t6_regrant", 16'h0200, 4'd9, 1'b1);
    // Other requests and mode change while held do not move the grant.
    req  = 16'h8203;
    mode = 1'b0;
    tick();
    check_out("t6_frozen", 16'h0200, 4'd9, 1'b1);
    // done and owner drop together: one release.
    req  = 16'h0000;
    done = 1'b1;
    tick();
    check_out("t6_both", 16'h0000, 4'd0, 1'b0);
    done = 1'b0;
    tick();
    check_out("t6_after", 16'h0000, 4'd0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
